// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;
  // Tick counter width; must hold the longest stop period (2 stop bits = 32 ticks).
  localparam int unsigned S_W        = 5;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchroniser with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detection, mid-bit data sampling (LSB first),
// stop-bit check, and a one-clock completion pulse with framing-error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int unsigned NW = $clog2(DBIT);

  rx_state_t       state;
  logic [S_W-1:0]  s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic            rx_sync;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_sync)
  );

  // busy is updated alongside every state change so it always equals (state != IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shreg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            s     <= '0;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (s_tick) begin
            if (s == S_W'(MID_TICK)) begin
              if (!rx_sync) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == S_W'(OVERSAMPLE - 1)) begin
              s     <= '0;
              shreg <= {rx_sync, shreg[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
                state <= STOP;
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + S_W'(1);
            end
          end
        end

        STOP: begin
          if (s_tick) begin
            if (s == S_W'(SB_TICK - 1)) begin
              state        <= IDLE;
              busy         <= 1'b0;
              dout         <= shreg;
              frame_err    <= ~rx_sync;
              rx_done_tick <= 1'b1;
            end else begin
              s <= s + S_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8-bit/1-stop instance plus a 7-bit/2-stop instance.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       s_tick;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] dout_a;
  logic       done_a;
  logic       ferr_a;
  logic       busy_a;
  logic [6:0] dout_b;
  logic       done_b;
  logic       ferr_b;
  logic       busy_b;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int frame_start = 0;

  // Monitor state for instance A
  int         done_cnt_a = 0;
  int         done_cyc_a = -1;
  int         prev_done_cyc_a = -1;
  logic [7:0] done_dout_a = '0;
  logic [7:0] prev_done_dout_a = '0;
  logic       done_ferr_a = 1'b0;
  logic       prev_done_ferr_a = 1'b0;
  logic       busy_at_done_a = 1'b0;
  logic       busy_prev_a = 1'b0;
  int         busy_rise_a = -1;
  int         busy_fall_a = -1;

  // Monitor state for instance B
  int         done_cnt_b = 0;
  int         done_cyc_b = -1;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tick      (s_tick),
    .rx          (rx_a),
    .dout        (dout_a),
    .rx_done_tick(done_a),
    .frame_err   (ferr_a),
    .busy        (busy_a)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tick      (s_tick),
    .rx          (rx_b),
    .dout        (dout_b),
    .rx_done_tick(done_b),
    .frame_err   (ferr_b),
    .busy        (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      done_cnt_a       = done_cnt_a + 1;
      prev_done_cyc_a  = done_cyc_a;
      prev_done_dout_a = done_dout_a;
      prev_done_ferr_a = done_ferr_a;
      done_cyc_a       = cycle;
      done_dout_a      = dout_a;
      done_ferr_a      = ferr_a;
      busy_at_done_a   = busy_a;
    end
    if (busy_a === 1'b1 && busy_prev_a === 1'b0) busy_rise_a = cycle;
    if (busy_a === 1'b0 && busy_prev_a === 1'b1) busy_fall_a = cycle;
    busy_prev_a = busy_a;
    if (done_b === 1'b1) begin
      done_cnt_b = done_cnt_b + 1;
      done_cyc_b = cycle;
    end
  end

  // Drive one line level for a number of clocks; leaves time at posedge+1.
  task automatic drive(input bit sel, input logic v, input int cycles);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input logic stop_val, input int stop_cycles);
    frame_start = cycle;
    drive(sel, 1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(sel, data[i], 16);
    drive(sel, stop_val, stop_cycles);
    if (sel) rx_b = 1'b1;
    else     rx_a = 1'b1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; s_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
    checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", ferr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_frame_a5;
    int cnt0;
    cnt0 = done_cnt_a;
    send_frame(1'b0, 9'h0A5, 8, 1'b1, 16);
    idle(20);
    checks++; if (done_cnt_a !== cnt0 + 1) begin errors++; $display("FAIL a5_done_count got %0d exp %0d", done_cnt_a - cnt0, 1); end
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL a5_dout got %h exp a5", dout_a); end
    checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL a5_ferr got %b exp 0", ferr_a); end
    checks++; if (done_cyc_a - frame_start !== 155) begin errors++; $display("FAIL a5_done_latency got %0d exp 155", done_cyc_a - frame_start); end
    checks++; if (busy_rise_a - frame_start !== 3) begin errors++; $display("FAIL a5_busy_rise got %0d exp 3", busy_rise_a - frame_start); end
    checks++; if (busy_fall_a - frame_start !== 155) begin errors++; $display("FAIL a5_busy_fall got %0d exp 155", busy_fall_a - frame_start); end
    checks++; if (busy_at_done_a !== 1'b0) begin errors++; $display("FAIL a5_busy_at_done got %b exp 0", busy_at_done_a); end
  endtask

  task automatic test_start_glitch;
    int cnt0;
    cnt0 = done_cnt_a;
    frame_start = cycle;
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 40);
    checks++; if (done_cnt_a !== cnt0) begin errors++; $display("FAIL glitch_no_done got %0d exp 0", done_cnt_a - cnt0); end
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL glitch_dout got %h exp a5", dout_a); end
    checks++; if (busy_rise_a - frame_start !== 3) begin errors++; $display("FAIL glitch_busy_rise got %0d exp 3", busy_rise_a - frame_start); end
    checks++; if (busy_fall_a - frame_start !== 11) begin errors++; $display("FAIL glitch_busy_fall got %0d exp 11", busy_fall_a - frame_start); end
  endtask

  task automatic test_frame_error;
    int cnt0;
    cnt0 = done_cnt_a;
    send_frame(1'b0, 9'h03C, 8, 1'b0, 16);
    idle(30);
    checks++; if (done_cnt_a !== cnt0 + 1) begin errors++; $display("FAIL ferr_done_count got %0d exp 1", done_cnt_a - cnt0); end
    checks++; if (dout_a !== 8'h3C) begin errors++; $display("FAIL ferr_dout got %h exp 3c", dout_a); end
    checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", ferr_a); end
    send_frame(1'b0, 9'h081, 8, 1'b1, 16);
    idle(20);
    checks++; if (dout_a !== 8'h81) begin errors++; $display("FAIL clean_dout got %h exp 81", dout_a); end
    checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL clean_ferr got %b exp 0", ferr_a); end
  endtask

  task automatic test_reset_mid_frame;
    int cnt0;
    cnt0 = done_cnt_a;
    frame_start = cycle;
    drive(1'b0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy_a); end
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h exp 00", dout_a); end
    checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b exp 0", ferr_a); end
    checks++; if (dut_a.state !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d exp 0", dut_a.state); end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    checks++; if (done_cnt_a !== cnt0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_cnt_a - cnt0); end
    send_frame(1'b0, 9'h055, 8, 1'b1, 16);
    idle(20);
    checks++; if (done_cnt_a !== cnt0 + 1) begin errors++; $display("FAIL postrst_done_count got %0d exp 1", done_cnt_a - cnt0); end
    checks++; if (dout_a !== 8'h55) begin errors++; $display("FAIL postrst_dout got %h exp 55", dout_a); end
  endtask

  task automatic test_back_to_back;
    int cnt0;
    cnt0 = done_cnt_a;
    send_frame(1'b0, 9'h000, 8, 1'b1, 16);
    send_frame(1'b0, 9'h0FF, 8, 1'b1, 16);
    idle(20);
    checks++; if (done_cnt_a !== cnt0 + 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt_a - cnt0); end
    checks++; if (prev_done_dout_a !== 8'h00) begin errors++; $display("FAIL b2b_first_dout got %h exp 00", prev_done_dout_a); end
    checks++; if (done_dout_a !== 8'hFF) begin errors++; $display("FAIL b2b_second_dout got %h exp ff", done_dout_a); end
    checks++; if (done_cyc_a - prev_done_cyc_a !== 160) begin errors++; $display("FAIL b2b_gap got %0d exp 160", done_cyc_a - prev_done_cyc_a); end
    checks++; if ((prev_done_ferr_a | done_ferr_a) !== 1'b0) begin errors++; $display("FAIL b2b_ferr got %b%b exp 00", prev_done_ferr_a, done_ferr_a); end
  endtask

  task automatic test_dbit7_two_stop;
    int cnt0;
    cnt0 = done_cnt_b;
    send_frame(1'b1, 9'h02A, 7, 1'b1, 32);
    idle(20);
    checks++; if (done_cnt_b !== cnt0 + 1) begin errors++; $display("FAIL d7_done_count got %0d exp 1", done_cnt_b - cnt0); end
    checks++; if (dout_b !== 7'h2A) begin errors++; $display("FAIL d7_dout got %h exp 2a", dout_b); end
    checks++; if (ferr_b !== 1'b0) begin errors++; $display("FAIL d7_ferr got %b exp 0", ferr_b); end
    checks++; if (done_cyc_b - frame_start !== 155) begin errors++; $display("FAIL d7_done_latency got %0d exp 155", done_cyc_b - frame_start); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_start_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_back_to_back();
    test_dbit7_two_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx
